// File: rtl/regfile_wb_sink.sv
// ---------------------------------------------------------------------------
// regfile_wb_sink
//
// General-purpose register file fed by the writeback stage. It provides one
// write port (we/waddr/wdata) and two combinational read ports for decode.
// A write is forwarded to a matching reader in the same cycle. x0 always
// reads as zero. After reset, a sequential clear engine zeroes one entry per
// ready cycle. It holds init_busy high until every entry has been cleared.
//
// Parameters
//   DATA_W   register width
//   ADDR_W   register address width
//   NREGS    number of entries, must equal 1 << ADDR_W
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (restarts the clear sweep)
//   rdy        global ready; 0 freezes every piece of state
//   we         writeback write enable
//   waddr      writeback destination register
//   wdata      writeback data
//   re1/re2    read port enables
//   raddr1/2   read port addresses
//   rdata1/2   read port data (combinational)
//   init_busy  registered; high while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_wb_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              init_busy
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [NREGS];

  logic run;
  logic wr_fire;

  // Read-port selection: disabled port, x0 and INIT all read as zero.
  // A live write to the same nonzero register is forwarded (bypass).
  function automatic logic [DATA_W-1:0] sel_read(
    input logic              en,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              in_run,
    input logic              fire,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (in_run && en && (ra != '0)) begin
      if (fire && (wa == ra)) r = wd;
      else                    r = stored;
    end
    return r;
  endfunction

  assign run     = (state == S_RUN);
  // Accepted write in RUN; x0 writes are dropped here, which also keeps the
  // bypass from ever forwarding to address 0.
  assign wr_fire = run && rdy && we && (waddr != '0);

  // Control: FSM, clear index and stall flag. Reset applies only here;
  // the array itself is cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      clr_idx   <= '0;
      init_busy <= 1'b1;
    end else if (rdy) begin
      case (state)
        S_INIT: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == LAST_IDX) begin
            state     <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN: begin
          state     <= S_RUN;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= S_INIT;
          clr_idx   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Array: sweep clear during INIT, writeback writes during RUN. Nothing is
  // written in a reset cycle or while rdy is low.
  always_ff @(posedge clk) begin
    if (!rst && rdy) begin
      if (!run)         mem[clr_idx] <= '0;
      else if (wr_fire) mem[waddr]   <= wdata;
    end
  end

  always_comb begin
    rdata1 = sel_read(re1, raddr1, mem[raddr1], run, wr_fire, waddr, wdata);
    rdata2 = sel_read(re2, raddr2, mem[raddr2], run, wr_fire, waddr, wdata);
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
module tb_regfile_wb_sink;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        init_busy;

  int errors = 0;
  int checks = 0;

  regfile_wb_sink #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus "how many entries cleared so far".
  logic [31:0] ref_mem [32];
  bit          ref_busy;
  int          ref_cleared;

  function automatic logic [31:0] exp_read(input bit en, input logic [4:0] ra);
    if (ref_busy || !en || ra == 5'd0) return 32'd0;
    if (rdy && we && waddr == ra)      return wdata;
    return ref_mem[ra];
  endfunction

  task automatic model_edge();
    if (rst) begin
      ref_busy    = 1'b1;
      ref_cleared = 0;
    end else if (rdy) begin
      if (ref_busy) begin
        ref_mem[ref_cleared] = 32'd0;
        ref_cleared++;
        if (ref_cleared == 32) ref_busy = 1'b0;
      end else if (we && waddr != 5'd0) begin
        ref_mem[waddr] = wdata;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit rd, input bit w, input logic [4:0] wa,
                       input logic [31:0] wd, input bit e1, input logic [4:0] a1,
                       input bit e2, input logic [4:0] a2);
    rst = r; rdy = rd; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  // Check combinational reads against the model, clock once, check init_busy.
  task automatic step(input bit chk_reads);
    #2;
    if (chk_reads) begin
      check("rdata1", rdata1, exp_read(re1, raddr1));
      check("rdata2", rdata2, exp_read(re2, raddr2));
    end
    @(posedge clk);
    model_edge();
    #1;
    check("init_busy", {31'd0, init_busy}, {31'd0, ref_busy});
  endtask

  task automatic idle_cycle(input bit rd);
    drive(1'b0, rd, 1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom), 1'b1, 5'($urandom));
    step(1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b0);
  endtask

  // Run idle ready cycles until init_busy falls; return how many it took.
  task automatic wait_init(output int n);
    n = 0;
    while (init_busy && n < 200) begin
      idle_cycle(1'b1);
      n++;
    end
  endtask

  typedef struct {
    bit          rdy;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    bit          re1;
    logic [4:0]  raddr1;
    bit          re2;
    logic [4:0]  raddr2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int n;
    vecs[0]  = '{1, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd5, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1, 1, 5'd0, 32'h12345678, 1, 5'd0, 1, 5'd5, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1, 0, 5'd0, 32'h0,        1, 5'd0, 1, 5'd0, 32'h0,        32'h0};
    vecs[4]  = '{1, 1, 5'd9, 32'h1,        1, 5'd9, 1, 5'd9, 32'h1,        32'h1};
    vecs[5]  = '{1, 0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 32'h1,        32'h0};
    vecs[6]  = '{1, 0, 5'd0, 32'h0,        0, 5'd5, 1, 5'd9, 32'h0,        32'h1};
    vecs[7]  = '{1, 1, 5'd7, 32'hCAFE0007, 1, 5'd7, 1, 5'd9, 32'hCAFE0007, 32'h1};
    vecs[8]  = '{0, 1, 5'd7, 32'hBAD00BAD, 1, 5'd7, 1, 5'd5, 32'hCAFE0007, 32'hDEADBEEF};
    vecs[9]  = '{1, 0, 5'd0, 32'h0,        1, 5'd7, 1, 5'd31, 32'hCAFE0007, 32'h0};
    vecs[10] = '{1, 1, 5'd31, 32'h31313131, 1, 5'd30, 1, 5'd31, 32'h0,      32'h31313131};

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    ref_busy = 1'b1;
    ref_cleared = 0;
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset then a full clear sweep of exactly 32 ready cycles.
    do_reset();
    check("reset_busy", {31'd0, init_busy}, 32'd1);
    wait_init(n);
    check("init_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      #2;
      check("clear_rd1", rdata1, 32'd0);
      check("clear_rd2", rdata2, 32'd0);
      step(1'b0);
    end

    // Directed vectors: bypass, x0 drops, shared address, disabled port, rdy=0.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vecs[i].rdy, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
      #2;
      check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].e2);
      step(1'b0);
    end

    // rdy low for 10 cycles during INIT stretches the sweep to 42 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) idle_cycle(1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'(i + 1), $urandom, 1'b1, 5'(i + 1), 1'b1, 5'd3);
      step(1'b1);
    end
    wait_init(n);
    check("init_len_stall", n + 15, 42);

    // Write x3, then reset mid-RUN: reads are zero during the re-clear and
    // after it; a write presented in the reset cycle is discarded.
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b1);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
    #2;
    check("x3_written", rdata1, 32'hA5A5A5A5);
    step(1'b0);
    drive(1'b1, 1'b1, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 1'b0, 5'd0);
    step(1'b0);
    check("rerst_busy", {31'd0, init_busy}, 32'd1);
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h77777777, 1'b1, 5'd3, 1'b1, 5'd3);
    #2;
    check("init_rd_zero", rdata1, 32'd0);
    step(1'b1);
    wait_init(n);
    check("init_len_rerst", n + 1, 32);
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4);
    #2;
    check("x3_cleared", rdata1, 32'd0);
    check("x4_cleared", rdata2, 32'd0);
    step(1'b0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bit          r;
      logic [4:0]  wa;
      r  = ($urandom_range(0, 299) == 0);
      wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      drive(r, ($urandom_range(0, 9) < 8), $urandom_range(0, 1), wa, $urandom,
            ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 5) != 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom));
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
